ssd_to_bin: RTL and testbench
=============================

SSD_TO_BIN -- requirements
Module: ssd_to_bin

Interface
REQ-001 Parameter: NDIG, 4, maximum digits per frame (legal 1..4); out_bcd and out_bin widths stay fixed at 16 and 14.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 seg_in  input  8  active-low segment pattern, bit7=a ... bit1=g, bit0=dp.
REQ-005 seg_valid  input  1  seg_in carries a digit this cycle.
REQ-006 seg_last  input  1  qualifies seg_valid; marks the final digit of the frame.
REQ-007 seg_ready  output  1  block accepts a digit this cycle.
REQ-008 out_valid  output  1  frame result is valid; held until accepted.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 out_bcd  output  16  decoded digits, BCD, right-justified, first-received digit most significant.
REQ-011 out_bin  output  14  binary value of the decoded digits.
REQ-012 out_ndig  output  3  number of digits stored, 1..NDIG.
REQ-013 out_err  output  1  frame contained an invalid pattern or too many digits.

Function
REQ-014 A digit SHALL be accepted on any cycle where seg_valid and seg_ready are both 1.
REQ-015 Decode SHALL use an exact 8-bit match on seg_in: 0x03->0, 0x9F->1, 0x25->2, 0x0D->3, 0x99->4, 0x49->5, 0x41->6, 0x1F->7, 0x01->8, 0x09->9.
REQ-016 Invalid pattern: any other seg_in SHALL decode as digit 0 and set the sticky frame error.
REQ-017 States SHALL be IDLE, ACCUM and DONE; IDLE is the reset state.
REQ-018 IDLE: seg_ready=1; an accepted digit clears the accumulators, stores the digit, and moves to ACCUM, or to DONE if seg_last=1.
REQ-019 ACCUM: seg_ready=1; each accepted digit is stored; an accepted digit with seg_last=1 moves to DONE.
REQ-020 Store operation: bcd <= {bcd[11:0], d}; bin <= bin*10 + d, computed as (bin<<3)+(bin<<1)+d; ndig increments.
REQ-021 Overflow: a digit accepted while ndig==NDIG SHALL leave bcd, bin and ndig unchanged and set the error flag; seg_last still ends the frame.
REQ-022 Latency: out_valid SHALL rise in the cycle after the digit with seg_last is accepted.
REQ-023 DONE: seg_ready=0, out_valid=1; out_bcd, out_bin, out_ndig and out_err are held stable; seg_valid is ignored.
REQ-024 In DONE, when out_valid and out_ready are both 1, the block SHALL move to IDLE, with out_valid=0 and seg_ready=1 in the next cycle.
REQ-025 Output data SHALL retain the last frame's values after hand-off until the next frame completes; out_valid alone qualifies them.
REQ-026 Maximum value 9999 SHALL fit out_bin without truncation; no other saturation logic is required.
REQ-027 seg_ready and out_valid SHALL be registered outputs; there is no combinational path from seg_valid or out_ready to any output.

Reset
REQ-028 When rst_n=0 at a clock edge: state IDLE, seg_ready=1, out_valid=0, out_bcd=0, out_bin=0, out_ndig=0, out_err=0, all accumulators and the error flag cleared.
REQ-029 Reset asserted mid-frame or in DONE SHALL discard the partial or pending frame with no out_valid pulse.

Verification
REQ-030 Scenario 1: 0x9F, 0x25, 0x0D, 0x99 (last), out_ready=1 -> out_valid 1 cycle after the last digit; out_bcd=0x1234, out_bin=1234, out_ndig=4, out_err=0.
REQ-031 Scenario 2: single 0x01 with seg_last -> out_bcd=0x0008, out_bin=8, out_ndig=1, out_err=0.
REQ-032 Scenario 3: 0x49, 0xFF, 0x1F (last) -> out_bcd=0x0507, out_bin=507, out_ndig=3, out_err=1.
REQ-033 Scenario 4: digits 1, 2, 3, 4, 5 (last) with NDIG=4 -> out_bcd=0x1234, out_bin=1234, out_ndig=4, out_err=1.
REQ-034 Scenario 5: out_ready held 0 for 3 cycles in DONE while seg_valid=1 -> outputs stable, seg_ready=0, no digit consumed; out_ready=1 -> IDLE next cycle.
REQ-035 Scenario 6: rst_n=0 for 1 cycle after 2 digits, then 0x09 (last) -> out_bcd=0x0009, out_bin=9, out_ndig=1, out_err=0.

Source files
------------

// File: rtl/ssd_to_bin.sv
// rtl/ssd_to_bin.sv - seven-segment digit frame decoder to BCD and binary
module ssd_to_bin #(
    parameter int NDIG = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  seg_in,
    input  logic        seg_valid,
    input  logic        seg_last,
    output logic        seg_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_bcd,
    output logic [13:0] out_bin,
    output logic [2:0]  out_ndig,
    output logic        out_err
);

    localparam logic [2:0] MAX_NDIG = 3'(NDIG);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] acc_bcd, acc_bcd_nxt, base_bcd;
    logic [13:0] acc_bin, acc_bin_nxt, base_bin;
    logic [2:0]  acc_ndig, acc_ndig_nxt, base_ndig;
    logic        acc_err, acc_err_nxt, base_err;
    logic [3:0]  digit;
    logic        digit_bad;
    logic        accept;

    // Both handshake outputs decode straight from the state flop, so neither
    // depends combinationally on seg_valid or out_ready.
    assign seg_ready = (state != DONE);
    assign out_valid = (state == DONE);
    assign accept    = seg_valid && seg_ready;

    always_comb begin
        digit     = 4'd0;
        digit_bad = 1'b0;
        case (seg_in)
            8'h03:   digit = 4'd0;
            8'h9F:   digit = 4'd1;
            8'h25:   digit = 4'd2;
            8'h0D:   digit = 4'd3;
            8'h99:   digit = 4'd4;
            8'h49:   digit = 4'd5;
            8'h41:   digit = 4'd6;
            8'h1F:   digit = 4'd7;
            8'h01:   digit = 4'd8;
            8'h09:   digit = 4'd9;
            default: digit_bad = 1'b1;
        endcase
    end

    // A digit accepted in IDLE starts a fresh frame, so it sees cleared accumulators.
    always_comb begin
        base_bcd  = acc_bcd;
        base_bin  = acc_bin;
        base_ndig = acc_ndig;
        base_err  = acc_err;
        if (state == IDLE) begin
            base_bcd  = 16'd0;
            base_bin  = 14'd0;
            base_ndig = 3'd0;
            base_err  = 1'b0;
        end

        acc_bcd_nxt  = base_bcd;
        acc_bin_nxt  = base_bin;
        acc_ndig_nxt = base_ndig;
        acc_err_nxt  = base_err | digit_bad;
        if (base_ndig == MAX_NDIG) begin
            acc_err_nxt = 1'b1;
        end else begin
            acc_bcd_nxt  = {base_bcd[11:0], digit};
            acc_bin_nxt  = (base_bin << 3) + (base_bin << 1) + 14'(digit);
            acc_ndig_nxt = base_ndig + 3'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, ACCUM: begin
                if (accept) state_nxt = seg_last ? DONE : ACCUM;
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc_bcd  <= 16'd0;
            acc_bin  <= 14'd0;
            acc_ndig <= 3'd0;
            acc_err  <= 1'b0;
            out_bcd  <= 16'd0;
            out_bin  <= 14'd0;
            out_ndig <= 3'd0;
            out_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                acc_bcd  <= acc_bcd_nxt;
                acc_bin  <= acc_bin_nxt;
                acc_ndig <= acc_ndig_nxt;
                acc_err  <= acc_err_nxt;
                if (seg_last) begin
                    out_bcd  <= acc_bcd_nxt;
                    out_bin  <= acc_bin_nxt;
                    out_ndig <= acc_ndig_nxt;
                    out_err  <= acc_err_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_ssd_to_bin.sv
// tb/tb_ssd_to_bin.sv - directed-vector bench for ssd_to_bin
module tb_ssd_to_bin;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  seg_in;
    logic        seg_valid;
    logic        seg_last;
    logic        seg_ready;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_bcd;
    logic [13:0] out_bin;
    logic [2:0]  out_ndig;
    logic        out_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ssd_to_bin #(.NDIG(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_in    (seg_in),
        .seg_valid (seg_valid),
        .seg_last  (seg_last),
        .seg_ready (seg_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .out_bin   (out_bin),
        .out_ndig  (out_ndig),
        .out_err   (out_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] s, input logic last);
        check("seg_ready_before_digit", {31'd0, seg_ready}, 32'd1);
        seg_in    = s;
        seg_valid = 1'b1;
        seg_last  = last;
        tick();
        seg_valid = 1'b0;
        seg_last  = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [15:0] bcd, input logic [13:0] bin,
                                input logic [2:0] nd, input logic err);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_bcd"},   {16'd0, out_bcd},   {16'd0, bcd});
        check({tag, "_bin"},   {18'd0, out_bin},   {18'd0, bin});
        check({tag, "_ndig"},  {29'd0, out_ndig},  {29'd0, nd});
        check({tag, "_err"},   {31'd0, out_err},   {31'd0, err});
    endtask

    task automatic handoff(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_ready_back"}, {31'd0, seg_ready}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; seg_in = 8'hFF; seg_valid = 1'b0; seg_last = 1'b0; out_ready = 1'b0;
        tick(); tick();
        check("rst_seg_ready", {31'd0, seg_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_bcd",  {16'd0, out_bcd},  32'd0);
        check("rst_bin",  {18'd0, out_bin},  32'd0);
        check("rst_ndig", {29'd0, out_ndig}, 32'd0);
        check("rst_err",  {31'd0, out_err},  32'd0);
        rst_n = 1'b1;
        tick();

        // 1 2 3 4
        send(8'h9F, 1'b0);
        check("s1_no_early_valid", {31'd0, out_valid}, 32'd0);
        send(8'h25, 1'b0);
        send(8'h0D, 1'b0);
        send(8'h99, 1'b1);
        check_result("s1", 16'h1234, 14'd1234, 3'd4, 1'b0);
        handoff("s1");
        check("s1_retain_bcd", {16'd0, out_bcd}, 32'h1234);

        // single 8
        send(8'h01, 1'b1);
        check_result("s2", 16'h0008, 14'd8, 3'd1, 1'b0);
        handoff("s2");

        // 5, invalid, 7
        send(8'h49, 1'b0);
        send(8'hFF, 1'b0);
        send(8'h1F, 1'b1);
        check_result("s3", 16'h0507, 14'd507, 3'd3, 1'b1);
        handoff("s3");

        // error must not leak into the next frame; also exercises 6 and 0
        send(8'h41, 1'b0);
        send(8'h03, 1'b1);
        check_result("s3b", 16'h0060, 14'd60, 3'd2, 1'b0);
        handoff("s3b");

        // overflow: 1 2 3 4 5
        send(8'h9F, 1'b0);
        send(8'h25, 1'b0);
        send(8'h0D, 1'b0);
        send(8'h99, 1'b0);
        send(8'h49, 1'b1);
        check_result("s4", 16'h1234, 14'd1234, 3'd4, 1'b1);

        // stall in DONE with seg_valid asserted
        seg_in = 8'h9F; seg_valid = 1'b1; seg_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s5_seg_ready", {31'd0, seg_ready}, 32'd0);
            check_result("s5_hold", 16'h1234, 14'd1234, 3'd4, 1'b1);
        end
        seg_valid = 1'b0; seg_last = 1'b0;
        handoff("s5");

        // 9 9 9 9 upper bound
        send(8'h09, 1'b0);
        send(8'h09, 1'b0);
        send(8'h09, 1'b0);
        send(8'h09, 1'b1);
        check_result("max", 16'h9999, 14'd9999, 3'd4, 1'b0);
        handoff("max");

        // reset mid-frame
        send(8'h9F, 1'b0);
        send(8'h25, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("s6_rst_valid", {31'd0, out_valid}, 32'd0);
        check("s6_rst_bcd",   {16'd0, out_bcd},   32'd0);
        send(8'h09, 1'b1);
        check_result("s6", 16'h0009, 14'd9, 3'd1, 1'b0);

        // reset while DONE drops the pending result
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("done_rst_valid", {31'd0, out_valid}, 32'd0);
        tick();
        check("done_rst_stays_idle", {31'd0, out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
